// File: rtl/memory_n_to_1_arbiter_pkg.sv
// Shared constants and sizing helpers for the N-to-1 memory arbiter.
// Tag records carry {valid, channel index, out-of-range flag} through the RAM read latency.
package memory_n_to_1_arbiter_pkg;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  // Channel index width; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int unsigned tag_width(input int unsigned num_ch);
    return idx_width(num_ch) + 2;
  endfunction

  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned CH_IDX_W   = idx_width(DEF_NUM_CH);
  localparam int unsigned TAG_W      = tag_width(DEF_NUM_CH);

endpackage

// File: rtl/rr_arbiter.sv
// N-way one-hot arbiter: fixed priority (ch0 highest) or round-robin from a rotating pointer.
// Grant is purely combinational from req and the registered pointer.
module rr_arbiter
  import memory_n_to_1_arbiter_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned MODE = ARB_RR,
  parameter int unsigned IW   = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cand_idx;
  int unsigned   start;
  int unsigned   cand;

  always_comb begin
    start    = (MODE == ARB_RR) ? 32'(ptr_q) : 0;
    gnt      = '0;
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // Scan N positions starting at the pointer, wrapping modulo N.
    for (int unsigned off = 0; off < N; off++) begin
      cand = start + off;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = IW'(cand);
      if (!gnt_any && req[cand_idx]) begin
        gnt_any       = 1'b1;
        gnt_idx       = cand_idx;
        gnt[cand_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if ((MODE == ARB_RR) && gnt_any) begin
      ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/single_port_mem.sv
// Single-port RAM with a registered read path of RD_LATENCY cycles.
// Contents are never reset; only the read pipeline carries data forward.
module single_port_mem #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 56,
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  q
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_q [RD_LATENCY];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= din;
    end
    rd_q[0] <= mem[addr];
    for (int i = 1; i < RD_LATENCY; i++) begin
      rd_q[i] <= rd_q[i-1];
    end
  end

  assign q = rd_q[RD_LATENCY-1];

endmodule

// File: rtl/memory_n_to_1_arbiter.sv
// Shares one single-port RAM between NUM_CH clients, each owning a SUB_DEPTH-word window.
// Reads are tagged through the RAM latency so each client sees its own rd_valid.
module memory_n_to_1_arbiter
  import memory_n_to_1_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned SUB_DEPTH      = 14,
  parameter int unsigned FULL_DEPTH     = NUM_CH * SUB_DEPTH,
  parameter int unsigned SUB_DEPTH_LOG  = $clog2(SUB_DEPTH),
  parameter int unsigned FULL_DEPTH_LOG = $clog2(FULL_DEPTH),
  parameter int unsigned RD_LATENCY     = 1,
  parameter int unsigned ARB_MODE       = ARB_RR
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CH-1:0]               ch_req,
  input  logic [NUM_CH-1:0]               ch_wr_en,
  input  logic [NUM_CH*SUB_DEPTH_LOG-1:0] ch_addr,
  input  logic [NUM_CH*WIDTH-1:0]         ch_din,
  output logic [NUM_CH-1:0]               ch_gnt,
  output logic [NUM_CH-1:0]               ch_rd_valid,
  output logic [WIDTH-1:0]                mem_dout,
  output logic                            addr_err
);

  localparam int unsigned IW = idx_width(NUM_CH);

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] ch;
    logic          oor;
  } tag_t;

  logic [IW-1:0]            gnt_idx;
  logic                     gnt_any;
  logic [SUB_DEPTH_LOG-1:0] sel_addr;
  logic [WIDTH-1:0]         sel_din;
  logic                     sel_wr;
  logic                     oor;
  logic [FULL_DEPTH_LOG-1:0] mem_addr;
  logic                     mem_wr_en;
  logic [WIDTH-1:0]         ram_q;
  tag_t                     tag_in;
  tag_t                     tag_out;
  tag_t                     tag_q [RD_LATENCY];
  logic                     addr_err_q;

  rr_arbiter #(
    .N    (NUM_CH),
    .MODE (ARB_MODE),
    .IW   (IW)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (ch_req),
    .gnt     (ch_gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // One-hot grant drives an AND-OR mux over the packed client buses.
  always_comb begin
    sel_addr = '0;
    sel_din  = '0;
    sel_wr   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_gnt[i]) begin
        sel_addr = sel_addr | ch_addr[i*SUB_DEPTH_LOG +: SUB_DEPTH_LOG];
        sel_din  = sel_din  | ch_din[i*WIDTH +: WIDTH];
        sel_wr   = sel_wr   | ch_wr_en[i];
      end
    end
  end

  always_comb begin
    oor       = gnt_any && (32'(sel_addr) >= SUB_DEPTH);
    mem_wr_en = gnt_any && sel_wr && !oor;
    mem_addr  = '0;
    // Out-of-window accesses are parked at address 0 so the RAM is never indexed past its end.
    if (gnt_any && !oor) begin
      mem_addr = FULL_DEPTH_LOG'(gnt_idx) * FULL_DEPTH_LOG'(SUB_DEPTH)
               + FULL_DEPTH_LOG'(sel_addr);
    end
  end

  single_port_mem #(
    .WIDTH      (WIDTH),
    .DEPTH      (FULL_DEPTH),
    .ADDR_W     (FULL_DEPTH_LOG),
    .RD_LATENCY (RD_LATENCY)
  ) u_mem (
    .clk   (clk),
    .wr_en (mem_wr_en),
    .addr  (mem_addr),
    .din   (sel_din),
    .q     (ram_q)
  );

  always_comb begin
    tag_in       = '0;
    tag_in.valid = gnt_any && !sel_wr;
    tag_in.ch    = gnt_idx;
    tag_in.oor   = oor;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_out = tag_q[RD_LATENCY-1];

  always_comb begin
    ch_rd_valid = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_rd_valid[i] = tag_out.valid && (tag_out.ch == IW'(i));
    end
    mem_dout = tag_out.oor ? '0 : ram_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err_q <= 1'b0;
    end else if (oor) begin
      addr_err_q <= 1'b1;
    end
  end

  assign addr_err = addr_err_q;

endmodule
